// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and arctangent table for the CORDIC vectoring block.
// Angles are degrees scaled by 2^16; centidegree constants serve the quadrant fold.
package cordic_pkg;

  localparam int unsigned KInv    = 39797;
  localparam int unsigned Cdeg90  = 9000;
  localparam int unsigned Cdeg180 = 18000;
  localparam int unsigned Cdeg360 = 36000;

  typedef enum logic [1:0] {
    StIdle,
    StRot,
    StPost
  } state_e;

  // atan(2^-i) in degrees * 2^16, rounded to nearest.
  function automatic logic [31:0] atan_lut(input logic [3:0] idx);
    logic [31:0] val;
    case (idx)
      4'd0:    val = 32'd2949120;
      4'd1:    val = 32'd1740967;
      4'd2:    val = 32'd919879;
      4'd3:    val = 32'd466945;
      4'd4:    val = 32'd234379;
      4'd5:    val = 32'd117304;
      4'd6:    val = 32'd58666;
      4'd7:    val = 32'd29335;
      4'd8:    val = 32'd14668;
      4'd9:    val = 32'd7334;
      4'd10:   val = 32'd3667;
      4'd11:   val = 32'd1833;
      4'd12:   val = 32'd917;
      4'd13:   val = 32'd458;
      4'd14:   val = 32'd229;
      default: val = 32'd115;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Maps a first-quadrant angle (0..9000 centidegrees) plus input sign bits to a full-circle
// phase in 0..35999 centidegrees.
module cordic_quadrant_fold
  import cordic_pkg::*;
(
  input  logic [13:0] a_i,
  input  logic        qx_i,
  input  logic        qy_i,
  output logic [15:0] angle_o
);

  logic [15:0] a_ext;
  logic [15:0] sum;

  always_comb begin
    a_ext = {2'b00, a_i};
    unique case ({qx_i, qy_i})
      2'b00: sum = a_ext;
      2'b10: sum = 16'(Cdeg180) - a_ext;
      2'b11: sum = 16'(Cdeg180) + a_ext;
      2'b01: sum = 16'(Cdeg360) - a_ext;
    endcase
    angle_o = (sum == 16'(Cdeg360)) ? 16'd0 : sum;
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring: (x, y) -> phase in centidegrees and magnitude.
// Define CORDIC_VEC_ROUND_EN for round-half-up of angle and magnitude instead of truncation.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned Iter = 16,
  parameter int unsigned Frac = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] angle_o,
  output logic [8:0]  mag_o
);

  localparam int FracShift = int'(Frac) - 16;

`ifdef CORDIC_VEC_ROUND_EN
  localparam logic signed [39:0] RndA = 40'sd1 <<< (Frac - 1);
  localparam logic signed [47:0] RndM = 48'sd1 <<< (Frac + 15);
`else
  localparam logic signed [39:0] RndA = '0;
  localparam logic signed [47:0] RndM = '0;
`endif

  state_e             state_q;
  logic signed [31:0] x_q, y_q, z_q;
  logic signed [31:0] x_d, y_d, z_d;
  logic [3:0]         cnt_q;
  logic               qx_q, qy_q, zero_q;
  logic               done_q;
  logic [15:0]        angle_q;
  logic [8:0]         mag_q;

  logic signed [8:0]  x_sx, y_sx;
  logic [8:0]         x_abs, y_abs;
  logic [31:0]        atan_raw;
  logic signed [31:0] atan_i;
  logic signed [39:0] a_prod, a_sh;
  logic signed [47:0] m_prod, m_sh;
  logic [13:0]        a_clamp;
  logic [8:0]         m_val;
  logic [15:0]        angle_fold;

  // Sign-extend before abs so -128 maps to +128.
  always_comb begin
    x_sx  = {x_i[7], x_i};
    y_sx  = {y_i[7], y_i};
    x_abs = x_sx[8] ? -x_sx : x_sx;
    y_abs = y_sx[8] ? -y_sx : y_sx;
  end

  always_comb begin
    atan_raw = atan_lut(cnt_q);
    if (FracShift >= 0) atan_i = $signed(atan_raw) <<< FracShift;
    else                atan_i = $signed(atan_raw) >>> (-FracShift);
    if (!y_q[31]) begin
      x_d = x_q + (y_q >>> cnt_q);
      y_d = y_q - (x_q >>> cnt_q);
      z_d = z_q + atan_i;
    end else begin
      x_d = x_q - (y_q >>> cnt_q);
      y_d = y_q + (x_q >>> cnt_q);
      z_d = z_q - atan_i;
    end
  end

  always_comb begin
    a_prod = $signed({{8{z_q[31]}}, z_q}) * $signed(40'd100);
    a_sh   = (a_prod + RndA) >>> Frac;
    // Residual rotation can leave z just outside 0..90 degrees; all-zero input
    // spins z to ~100 degrees and is forced to zero.
    if (zero_q || a_sh < 0)                  a_clamp = 14'd0;
    else if (a_sh > $signed(40'(Cdeg90)))    a_clamp = 14'(Cdeg90);
    else                                     a_clamp = a_sh[13:0];

    m_prod = $signed({{16{x_q[31]}}, x_q}) * $signed(48'(KInv));
    m_sh   = (m_prod + RndM) >>> (Frac + 16);
    if (m_sh < 0)                    m_val = 9'd0;
    else if (m_sh > 48'sd511)        m_val = 9'd511;
    else                             m_val = m_sh[8:0];
  end

  cordic_quadrant_fold u_fold (
    .a_i     (a_clamp),
    .qx_i    (qx_q),
    .qy_i    (qy_q),
    .angle_o (angle_fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      qx_q    <= 1'b0;
      qy_q    <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            x_q     <= 32'(x_abs) << Frac;
            y_q     <= 32'(y_abs) << Frac;
            z_q     <= '0;
            cnt_q   <= '0;
            qx_q    <= x_i[7];
            qy_q    <= y_i[7];
            zero_q  <= (x_i == 8'd0) && (y_i == 8'd0);
            state_q <= StRot;
          end
        end
        StRot: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(Iter - 1)) state_q <= StPost;
        end
        StPost: begin
          angle_q <= angle_fold;
          mag_q   <= m_val;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign done_o  = done_q;
  assign angle_o = angle_q;
  assign mag_o   = mag_q;

endmodule
